pool_ctrl: RTL and testbench

POOL_CTRL -- requirements
Module: pool_ctrl

---
 rtl/pool_ctrl.sv | 123 ++++++++++++
 tb/tb_pool_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pool_ctrl.sv
// 2x2 binary max-pool (OR) controller for channel-sequential 8x8 bit-plane frames.
// A row pair produces one 4-bit pooled row; a single even row can be buffered while output is held.
module pool_ctrl #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_row,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_row,
  output logic [1:0]      out_rowidx,
  output logic [CH_W-1:0] out_chan,
  output logic            out_last,
  output logic            frame_done
);

  typedef enum logic [1:0] {
    S_EVEN   = 2'd0,
    S_ODD    = 2'd1,
    S_HOLD   = 2'd2,
    S_HOLD_E = 2'd3
  } state_e;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_e          state_q, state_d;
  logic [7:0]      even_q, even_d;
  logic [3:0]      out_row_q, out_row_d;
  logic [1:0]      pair_q, pair_d;
  logic [CH_W-1:0] chan_q, chan_d;
  logic            frame_done_q, frame_done_d;

  logic            in_acc;
  logic            out_hs;
  logic [3:0]      pooled;

  assign in_ready   = (state_q != S_HOLD_E);
  assign out_valid  = (state_q == S_HOLD) || (state_q == S_HOLD_E);
  assign out_row    = out_row_q;
  assign out_rowidx = pair_q;
  assign out_chan   = chan_q;
  assign out_last   = out_valid && (pair_q == 2'd3) && (chan_q == LAST_CH);
  assign frame_done = frame_done_q;

  assign in_acc = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // Each pooled column ORs a 2x2 window: two columns of the buffered even row and the incoming odd row.
  always_comb begin
    pooled = 4'h0;
    for (int j = 0; j < 4; j++) begin
      pooled[j] = even_q[2*j] | even_q[2*j+1] | in_row[2*j] | in_row[2*j+1];
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    even_d       = even_q;
    out_row_d    = out_row_q;
    pair_d       = pair_q;
    chan_d       = chan_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_EVEN: begin
        if (in_acc) begin
          even_d  = in_row;
          state_d = S_ODD;
        end
      end
      S_ODD: begin
        if (in_acc) begin
          out_row_d = pooled;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (in_acc) even_d = in_row;
        if (out_hs && in_acc)  state_d = S_ODD;
        else if (out_hs)       state_d = S_EVEN;
        else if (in_acc)       state_d = S_HOLD_E;
      end
      S_HOLD_E: begin
        if (out_hs) state_d = S_ODD;
      end
      default: state_d = S_EVEN;
    endcase

    // Position counters describe the held output, so they move only when it is consumed.
    if (out_hs) begin
      frame_done_d = out_last;
      pair_d       = pair_q + 2'd1;
      if (pair_q == 2'd3) begin
        chan_d = (chan_q == LAST_CH) ? '0 : chan_q + CH_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_EVEN;
      even_q       <= 8'h00;
      out_row_q    <= 4'h0;
      pair_q       <= 2'd0;
      chan_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      even_q       <= even_d;
      out_row_q    <= out_row_d;
      pair_q       <= pair_d;
      chan_q       <= chan_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl: a reference model pushes expected pooled rows to a queue on
// each completed input pair and pops/compares them on each output handshake.
module tb_pool_ctrl;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_row;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_row;
  logic [1:0]      out_rowidx;
  logic [CH_W-1:0] out_chan;
  logic            out_last;
  logic            frame_done;

  pool_ctrl #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row     (in_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_rowidx (out_rowidx),
    .out_chan   (out_chan),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] row;
    logic [1:0] idx;
    int         chan;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic       m_even_vld;
  logic [7:0] m_even;
  int         gen_pair;
  int         gen_chan;
  int         fd_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference 2x2 OR pool: pooled bit j is set when any of the four source bits is set.
  function automatic logic [3:0] ref_pool(input logic [7:0] e, input logic [7:0] o);
    logic [7:0] merged;
    logic [3:0] r;
    merged = e | o;
    r = 4'h0;
    for (int j = 0; j < 4; j++) r[j] = ((merged >> (2 * j)) & 8'h03) != 8'h00;
    return r;
  endfunction

  task automatic model_clear();
    sb.delete();
    m_even_vld = 1'b0;
    m_even     = 8'h00;
    gen_pair   = 0;
    gen_chan   = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_row    = 8'h00;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock: drive inputs at the falling edge, check against the model, then advance.
  task automatic step(input logic v, input logic [7:0] row, input logic ordy);
    exp_t e;
    logic pend, hs, acc, ir_exp, fd_exp;
    in_valid  = v;
    in_row    = row;
    out_ready = ordy;
    pend   = sb.size() > 0;
    ir_exp = !(pend && m_even_vld);
    check("in_ready", 32'(in_ready), 32'(ir_exp));
    check("out_valid", 32'(out_valid), 32'(pend));
    hs     = pend && ordy;
    fd_exp = 1'b0;
    if (pend) begin
      e = sb[0];
      check("out_row", 32'(out_row), 32'(e.row));
      check("out_rowidx", 32'(out_rowidx), 32'(e.idx));
      check("out_chan", 32'(out_chan), 32'(e.chan));
      check("out_last", 32'(out_last), 32'(e.last));
      if (hs) begin
        void'(sb.pop_front());
        fd_exp = e.last;
      end
    end else begin
      check("out_last_idle", 32'(out_last), 32'h0);
    end
    acc = v && ir_exp;
    if (acc) begin
      if (m_even_vld) begin
        e.row  = ref_pool(m_even, row);
        e.idx  = 2'(gen_pair);
        e.chan = gen_chan;
        e.last = (gen_pair == 3) && (gen_chan == NUM_CH - 1);
        sb.push_back(e);
        m_even_vld = 1'b0;
        gen_pair   = (gen_pair + 1) % 4;
        if (gen_pair == 0) gen_chan = (gen_chan + 1) % NUM_CH;
      end else begin
        m_even     = row;
        m_even_vld = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("frame_done", 32'(frame_done), 32'(fd_exp));
    if (frame_done === 1'b1) fd_count++;
  endtask

  initial begin
    model_clear();
    fd_count = 0;
    @(negedge clk);

    // Reset values
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_row", 32'(out_row), 32'h0);

    // Single pair: 01/80 -> 1001, output valid the cycle after the odd row
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h80, 1'b1);
    check("pair_out_row", 32'(out_row), 32'h9);
    step(1'b0, 8'h00, 1'b1);

    // Backpressure: fill HOLD_E, offer an ignored row, then release
    step(1'b1, 8'h30, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h0F, 1'b0);
    check("bp_in_ready_low", 32'(in_ready), 32'h0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("bp_in_ready_back", 32'(in_ready), 32'h1);
    step(1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Full frame of all-ones rows, streaming with out_ready high
    do_reset();
    fd_count = 0;
    for (int r = 0; r < 8 * NUM_CH; r++) step(1'b1, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("frame_done_count", 32'(fd_count), 32'h1);
    check("wrap_rowidx", 32'(out_rowidx), 32'h0);
    check("wrap_chan", 32'(out_chan), 32'h0);

    // Pattern pairs
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'hAA, 1'b1);
    step(1'b1, 8'h55, 1'b1);
    step(1'b1, 8'h0C, 1'b1);
    step(1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Reset mid-frame after five accepted rows
    for (int r = 0; r < 5; r++) step(1'b1, 8'hFF, 1'b1);
    do_reset();
    step(1'b1, 8'h03, 1'b1);
    step(1'b1, 8'h00, 1'b1);
    check("post_rst_row", 32'(out_row), 32'h1);
    check("post_rst_idx", 32'(out_rowidx), 32'h0);
    check("post_rst_chan", 32'(out_chan), 32'h0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
